store_commit_drain: RTL and testbench
=====================================

# store_commit_drain

In-order drain stage between the store queue's committed-store port and the store commit buffer. Accepts up to two retired stores per cycle, converts each from byte address, size and raw data into word address, byte mask and lane-aligned data, and buffers them in a FIFO. It presents them oldest-first on the commit buffer's write port, holding them whenever the commit buffer signals conflict. It also reports drain status for fence/sfence sequencing.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least PIPE.
- PIPE, 2: lanes per cycle; equals `STORE_PIPELINE.
- PADDR_SIZE, 32: physical address width.
- BYTE_W, 2: `DCACHE_BYTE_WIDTH; word is 2^BYTE_W bytes.
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  PIPE  committed stores; contiguous from lane 0 (in_valid[1] implies in_valid[0]).
- in_paddr  in  PIPE×PADDR_SIZE  byte address.
- in_size  in  PIPE×2  0=byte, 1=half, 2=word.
- in_data  in  PIPE×32  store data, right-justified.
- in_ready  out  1  the whole lane group is accepted when in_ready is high.
- out_en  out  PIPE  entries valid toward the commit buffer.
- out_addr  out  PIPE×(PADDR_SIZE-BYTE_W)  word address.
- out_mask  out  PIPE×2^BYTE_W  byte enables.
- out_data  out  PIPE×32  lane-aligned data.
- sc_conflict  in  1  commit buffer did not capture this cycle's outputs.
- drained  out  1  FIFO empty and out_en all zero.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

## Operation
- Push: every in_valid lane is written when in_ready is high, lane 0 first, at wptr and wptr+1 modulo DEPTH. Lanes presented while in_ready is low are ignored; the upstream must hold them.
- in_ready = (DEPTH - occupancy) >= PIPE. It is computed from registered occupancy only; same-cycle pops do not raise it.
- Alignment is done at push time. byte: mask = 1<<a[1:0], data << 8*a[1:0]. half: mask = 2'b11<<{a[1],1'b0}, data << 16*a[1]. word: mask = 4'hf, data unchanged. The address bits that a given size does not use are ignored, and no misalignment check is made. Size 3 is treated as word, and a simulation assertion fires.
- Output stage is a register set per lane. In any cycle with sc_conflict=0, it loads min(PIPE, occupancy) entries from rptr, oldest into lane 0. Unused lanes get out_en=0. rptr and occupancy advance by the number loaded.
- While sc_conflict=1, the output registers and rptr hold, and pushes continue.
- Outputs never reorder. Lane 1 is never valid without lane 0.
- occupancy_next = occupancy + pushed - popped. It is never above DEPTH; an overflow is an assertion failure.
- drained = (occupancy==0) & ~|out_en.

## Timing
- Reset (rst=0, asynchronous): wptr, rptr and occupancy go to 0; out_en=0; out_addr, out_mask and out_data go to 0; in_ready=1; drained=1.
- Latency: a store accepted at cycle t appears on out_en at t+2 if sc_conflict stays low. There is no bypass.
- Throughput is PIPE stores per cycle sustained.
- sc_conflict is sampled combinationally in the same cycle as out_*. The entries being presented are retained until the first cycle with sc_conflict=0 after them, and the load happens at the end of that cycle.
- Full FIFO: in_ready=0 and pushes are blocked. A pop in that cycle raises in_ready in the next cycle.
- Empty FIFO with sc_conflict=0: out_en goes to 0 in the next cycle.
- Simultaneous push and pop: both are applied. Pointers wrap modulo DEPTH with no bubble.
- Reset mid-operation discards buffered stores. This is legal only with the core halted.

## Structure
- Package entries: struct StoreDrainEntry with addr[PADDR_SIZE-BYTE_W], mask[2^BYTE_W] and data[32]; localparam STORE_SIZE_B/H/W = 0/1/2.
- The FIFO stores StoreDrainEntry.
- Sub-module store_drain_align: combinational per-lane size/offset to mask/data conversion, instantiated PIPE times.

## Test plan
- Single sb, paddr=0x8000_0003, data=0xAB, sc_conflict=0 → at t+2: out_en=01, out_addr=0x2000_0000, out_mask=1000, out_data=0xAB00_0000; then drained=1.
- Pair of stores: sh at 0x100 (data 0x1234) and sw at 0x104 (data 0xDEADBEEF) → next-but-one cycle: lane0 mask=0011 data=0x0000_1234 addr=0x40; lane1 mask=1111 data=0xDEADBEEF addr=0x41.
- Hold sc_conflict=1 for 3 cycles while pushing 2 stores per cycle → out_* stable throughout; occupancy reaches 6; after release, entries emerge in push order with none lost.
- Fill FIFO to 8 with sc_conflict=1 → in_ready=0 and the held input is not written; one sc_conflict=0 cycle pops 2; in_ready=1 the next cycle.
- Three stores total, then idle → the second output cycle has out_en=01; the third has out_en=00 and drained=1.
- Assert rst low with occupancy=5 and out_en=11 → occupancy=0, out_en=00 and drained=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/store_commit_drain_pkg.sv
// Shared types for the committed-store drain stage: the buffered entry format
// and the store size encodings coming from the store queue.
package store_commit_drain_pkg;

    localparam int SD_PADDR_SIZE = 32;
    localparam int SD_BYTE_W     = 2;
    localparam int SD_MASK_W     = 1 << SD_BYTE_W;

    localparam logic [1:0] STORE_SIZE_B = 2'd0;
    localparam logic [1:0] STORE_SIZE_H = 2'd1;
    localparam logic [1:0] STORE_SIZE_W = 2'd2;

    typedef struct packed {
        logic [SD_PADDR_SIZE-SD_BYTE_W-1:0] addr;
        logic [SD_MASK_W-1:0]               mask;
        logic [31:0]                        data;
    } StoreDrainEntry;

endpackage

// File: rtl/store_drain_align.sv
// Converts one store (byte address, size, right-justified data) into a word
// address, byte mask and lane-aligned data. Purely combinational.
module store_drain_align
    import store_commit_drain_pkg::*;
(
    input  logic [SD_PADDR_SIZE-1:0] paddr,
    input  logic [1:0]               size,
    input  logic [31:0]              data,
    output StoreDrainEntry           entry
);

    logic [1:0] offset;
    assign offset = paddr[1:0];

    // Offset bits a size does not use are ignored; size 3 falls through to word.
    always_comb begin
        entry.addr = paddr[SD_PADDR_SIZE-1:SD_BYTE_W];
        case (size)
            STORE_SIZE_B: begin
                entry.mask = 4'b0001 << offset;
                entry.data = data << {offset, 3'b000};
            end
            STORE_SIZE_H: begin
                entry.mask = 4'b0011 << {offset[1], 1'b0};
                entry.data = data << {offset[1], 4'b0000};
            end
            default: begin
                entry.mask = 4'hf;
                entry.data = data;
            end
        endcase
    end

endmodule

// File: rtl/store_commit_drain.sv
// In-order drain between the store queue commit port and the store commit
// buffer: aligns up to PIPE stores per cycle, buffers them, presents oldest-first.
module store_commit_drain
    import store_commit_drain_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PIPE       = 2,
    parameter int PADDR_SIZE = SD_PADDR_SIZE,
    parameter int BYTE_W     = SD_BYTE_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PIPE-1:0]                         in_valid,
    input  logic [PIPE-1:0][PADDR_SIZE-1:0]         in_paddr,
    input  logic [PIPE-1:0][1:0]                    in_size,
    input  logic [PIPE-1:0][31:0]                   in_data,
    output logic                                    in_ready,
    output logic [PIPE-1:0]                         out_en,
    output logic [PIPE-1:0][PADDR_SIZE-BYTE_W-1:0]  out_addr,
    output logic [PIPE-1:0][(1<<BYTE_W)-1:0]        out_mask,
    output logic [PIPE-1:0][31:0]                   out_data,
    input  logic                                    sc_conflict,
    output logic                                    drained,
    output logic [$clog2(DEPTH):0]                  occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  push_cnt;
    logic [CW-1:0]  pop_cnt;
    logic [CW:0]    occ_next;

    StoreDrainEntry mem     [DEPTH];
    StoreDrainEntry aligned [PIPE];
    StoreDrainEntry out_q   [PIPE];

    // Registered occupancy only: a pop in this cycle cannot open room for a push.
    assign in_ready = (CW'(DEPTH) - occupancy) >= CW'(PIPE);
    assign drained  = (occupancy == '0) && !(|out_en);

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < PIPE; i++) begin
            if (in_ready && in_valid[i]) push_cnt = push_cnt + CW'(1);
        end
    end

    always_comb begin
        pop_cnt = '0;
        if (!sc_conflict) pop_cnt = (occupancy < CW'(PIPE)) ? occupancy : CW'(PIPE);
    end

    assign occ_next = {1'b0, occupancy} + {1'b0, push_cnt} - {1'b0, pop_cnt};

    // Lanes are contiguous from lane 0, so lane i lands at wptr+i.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE; i++) begin
            if (in_ready && in_valid[i]) mem[wptr + PW'(i)] <= aligned[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
            out_en    <= '0;
            for (int i = 0; i < PIPE; i++) out_q[i] <= '0;
        end else begin
            wptr      <= wptr + PW'(push_cnt);
            occupancy <= occ_next[CW-1:0];
            if (!sc_conflict) begin
                rptr <= rptr + PW'(pop_cnt);
                for (int i = 0; i < PIPE; i++) begin
                    if (CW'(i) < occupancy) begin
                        out_en[i] <= 1'b1;
                        out_q[i]  <= mem[rptr + PW'(i)];
                    end else begin
                        out_en[i] <= 1'b0;
                        out_q[i]  <= '0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < PIPE; g++) begin : g_lane
        store_drain_align u_align (
            .paddr (in_paddr[g]),
            .size  (in_size[g]),
            .data  (in_data[g]),
            .entry (aligned[g])
        );

        assign out_addr[g] = out_q[g].addr;
        assign out_mask[g] = out_q[g].mask;
        assign out_data[g] = out_q[g].data;

        a_size_legal: assert property (@(posedge clk) disable iff (!rst)
            (in_ready && in_valid[g]) |-> (in_size[g] != 2'd3));
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        occ_next <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_store_commit_drain.sv
// Directed bench for store_commit_drain: alignment vectors plus hand-written
// sequences for conflict hold, full FIFO, tail drain and mid-run reset.
module tb_store_commit_drain;

    logic             clk;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0][31:0] in_paddr;
    logic [1:0][1:0]  in_size;
    logic [1:0][31:0] in_data;
    logic             in_ready;
    logic [1:0]       out_en;
    logic [1:0][29:0] out_addr;
    logic [1:0][3:0]  out_mask;
    logic [1:0][31:0] out_data;
    logic             sc_conflict;
    logic             drained;
    logic [3:0]       occupancy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [61:0] exp_q[$];

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] paddr0;
        logic [1:0]  size0;
        logic [31:0] data0;
        logic [31:0] paddr1;
        logic [1:0]  size1;
        logic [31:0] data1;
        logic [1:0]  en;
        logic [29:0] addr0;
        logic [3:0]  mask0;
        logic [31:0] odata0;
        logic [29:0] addr1;
        logic [3:0]  mask1;
        logic [31:0] odata1;
    } vec_t;

    vec_t vecs[6];

    store_commit_drain dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_paddr    (in_paddr),
        .in_size     (in_size),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_en      (out_en),
        .out_addr    (out_addr),
        .out_mask    (out_mask),
        .out_data    (out_data),
        .sc_conflict (sc_conflict),
        .drained     (drained),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        in_valid[l] = 1'b1;
        in_paddr[l] = a;
        in_size[l]  = s;
        in_data[l]  = d;
    endtask

    // Two word stores at a and a+4; data derived from the address.
    task automatic push_pair(input logic [31:0] a);
        logic [31:0] a1;
        a1 = a + 32'd4;
        in_valid = 2'b00;
        set_lane(0, a, 2'd2, a ^ 32'h5555_0000);
        set_lane(1, a1, 2'd2, a1 ^ 32'h5555_0000);
        exp_q.push_back({a[31:2], a ^ 32'h5555_0000});
        exp_q.push_back({a1[31:2], a1 ^ 32'h5555_0000});
    endtask

    // Releases the commit buffer and checks everything in exp_q emerges in order.
    task automatic drain_check(input string tag);
        int budget;
        logic [61:0] e;
        budget = 20;
        in_valid = 2'b00;
        sc_conflict = 1'b0;
        while ((exp_q.size() != 0 || !drained) && budget > 0) begin
            if (out_en[1]) check({tag, "_lane_order"}, 64'(out_en), 64'(2'b11));
            for (int l = 0; l < 2; l++) begin
                if (out_en[l]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL %s_extra: got addr 0x%0h expected no entry", tag, out_addr[l]);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_addr"}, 64'(out_addr[l]), 64'(e[61:32]));
                        check({tag, "_data"}, 64'(out_data[l]), 64'(e[31:0]));
                    end
                end
            end
            tick();
            budget--;
        end
        check({tag, "_remaining"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_drained"}, 64'(drained), 64'd1);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{valid: 2'b01, paddr0: 32'h8000_0003, size0: 2'd0, data0: 32'hAB,
                    paddr1: 32'h0, size1: 2'd0, data1: 32'h0,
                    en: 2'b01, addr0: 30'h2000_0000, mask0: 4'b1000, odata0: 32'hAB00_0000,
                    addr1: 30'h0, mask1: 4'h0, odata1: 32'h0};
        vecs[1] = '{valid: 2'b11, paddr0: 32'h100, size0: 2'd1, data0: 32'h1234,
                    paddr1: 32'h104, size1: 2'd2, data1: 32'hDEAD_BEEF,
                    en: 2'b11, addr0: 30'h40, mask0: 4'b0011, odata0: 32'h0000_1234,
                    addr1: 30'h41, mask1: 4'b1111, odata1: 32'hDEAD_BEEF};
        vecs[2] = '{valid: 2'b01, paddr0: 32'h10, size0: 2'd0, data0: 32'h5A,
                    paddr1: 32'h0, size1: 2'd0, data1: 32'h0,
                    en: 2'b01, addr0: 30'h4, mask0: 4'b0001, odata0: 32'h5A,
                    addr1: 30'h0, mask1: 4'h0, odata1: 32'h0};
        vecs[3] = '{valid: 2'b11, paddr0: 32'h202, size0: 2'd1, data0: 32'hBEEF,
                    paddr1: 32'h205, size1: 2'd0, data1: 32'h77,
                    en: 2'b11, addr0: 30'h80, mask0: 4'b1100, odata0: 32'hBEEF_0000,
                    addr1: 30'h81, mask1: 4'b0010, odata1: 32'h0000_7700};
        vecs[4] = '{valid: 2'b11, paddr0: 32'h303, size0: 2'd2, data0: 32'h1122_3344,
                    paddr1: 32'h001, size1: 2'd1, data1: 32'hCAFE,
                    en: 2'b11, addr0: 30'hC0, mask0: 4'b1111, odata0: 32'h1122_3344,
                    addr1: 30'h0, mask1: 4'b0011, odata1: 32'h0000_CAFE};
        vecs[5] = '{valid: 2'b01, paddr0: 32'hFFFF_FFFE, size0: 2'd0, data0: 32'hC3,
                    paddr1: 32'h0, size1: 2'd0, data1: 32'h0,
                    en: 2'b01, addr0: 30'h3FFF_FFFF, mask0: 4'b0100, odata0: 32'h00C3_0000,
                    addr1: 30'h0, mask1: 4'h0, odata1: 32'h0};

        // Clock and reset
        in_valid    = 2'b00;
        in_paddr    = '0;
        in_size     = '0;
        in_data     = '0;
        sc_conflict = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_en", 64'(out_en), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_drained", 64'(drained), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Alignment vectors, one lane group at a time from an empty FIFO
        for (int v = 0; v < 6; v++) begin
            in_valid = 2'b00;
            set_lane(0, vecs[v].paddr0, vecs[v].size0, vecs[v].data0);
            set_lane(1, vecs[v].paddr1, vecs[v].size1, vecs[v].data1);
            in_valid = vecs[v].valid;
            sc_conflict = 1'b0;
            tick();
            in_valid = 2'b00;
            check($sformatf("v%0d_no_bypass", v), 64'(out_en), 64'd0);
            tick();
            check($sformatf("v%0d_en", v), 64'(out_en), 64'(vecs[v].en));
            check($sformatf("v%0d_addr0", v), 64'(out_addr[0]), 64'(vecs[v].addr0));
            check($sformatf("v%0d_mask0", v), 64'(out_mask[0]), 64'(vecs[v].mask0));
            check($sformatf("v%0d_data0", v), 64'(out_data[0]), 64'(vecs[v].odata0));
            if (vecs[v].en[1]) begin
                check($sformatf("v%0d_addr1", v), 64'(out_addr[1]), 64'(vecs[v].addr1));
                check($sformatf("v%0d_mask1", v), 64'(out_mask[1]), 64'(vecs[v].mask1));
                check($sformatf("v%0d_data1", v), 64'(out_data[1]), 64'(vecs[v].odata1));
            end
            tick();
            check($sformatf("v%0d_idle_en", v), 64'(out_en), 64'd0);
            check($sformatf("v%0d_drained", v), 64'(drained), 64'd1);
        end

        // Conflict hold: outputs frozen while pairs keep arriving
        sc_conflict = 1'b0;
        push_pair(32'h1000);
        tick();
        in_valid = 2'b00;
        tick();
        check("hold_first_en", 64'(out_en), 64'(2'b11));
        sc_conflict = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_pair(32'h1008 + 32'(8 * k));
            tick();
            check($sformatf("hold%0d_en", k), 64'(out_en), 64'(2'b11));
            check($sformatf("hold%0d_addr0", k), 64'(out_addr[0]), 64'h400);
            check($sformatf("hold%0d_addr1", k), 64'(out_addr[1]), 64'h401);
            check($sformatf("hold%0d_occ", k), 64'(occupancy), 64'(2 * (k + 1)));
        end
        in_valid = 2'b00;
        drain_check("hold");

        // Full FIFO: held input is refused until a pop frees room
        sc_conflict = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_pair(32'h2000 + 32'(8 * k));
            tick();
        end
        check("full_occ", 64'(occupancy), 64'd8);
        check("full_ready", 64'(in_ready), 64'd0);
        push_pair(32'h3000);
        tick();
        check("full_blocked_occ", 64'(occupancy), 64'd8);
        check("full_blocked_ready", 64'(in_ready), 64'd0);
        sc_conflict = 1'b0;
        tick();
        check("full_pop_occ", 64'(occupancy), 64'd6);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        check("full_pop_en", 64'(out_en), 64'(2'b11));
        check("full_pop_addr0", 64'(out_addr[0]), 64'h800);
        sc_conflict = 1'b1;
        tick();
        check("full_refill_occ", 64'(occupancy), 64'd8);
        in_valid = 2'b00;
        drain_check("full");

        // Three stores then idle: tail lane group is half-populated
        sc_conflict = 1'b0;
        in_valid = 2'b00;
        set_lane(0, 32'h4000, 2'd2, 32'h0A0A_0A0A);
        set_lane(1, 32'h4004, 2'd2, 32'h0B0B_0B0B);
        tick();
        in_valid = 2'b00;
        set_lane(0, 32'h4010, 2'd2, 32'h0C0C_0C0C);
        tick();
        in_valid = 2'b00;
        check("tail_first_en", 64'(out_en), 64'(2'b11));
        tick();
        check("tail_second_en", 64'(out_en), 64'(2'b01));
        check("tail_second_addr", 64'(out_addr[0]), 64'h1004);
        check("tail_second_data", 64'(out_data[0]), 64'h0C0C_0C0C);
        check("tail_second_drained", 64'(drained), 64'd0);
        tick();
        check("tail_third_en", 64'(out_en), 64'd0);
        check("tail_third_drained", 64'(drained), 64'd1);

        // Reset while busy: occupancy 5 with both output lanes valid
        sc_conflict = 1'b0;
        in_valid = 2'b00;
        set_lane(0, 32'h5000, 2'd2, 32'h1);
        set_lane(1, 32'h5004, 2'd2, 32'h2);
        tick();
        set_lane(0, 32'h5008, 2'd2, 32'h3);
        set_lane(1, 32'h500C, 2'd2, 32'h4);
        tick();
        sc_conflict = 1'b1;
        set_lane(0, 32'h5010, 2'd2, 32'h5);
        set_lane(1, 32'h5014, 2'd2, 32'h6);
        tick();
        in_valid = 2'b00;
        set_lane(0, 32'h5018, 2'd2, 32'h7);
        tick();
        in_valid = 2'b00;
        check("busy_occ", 64'(occupancy), 64'd5);
        check("busy_en", 64'(out_en), 64'(2'b11));
        rst = 1'b0;
        #1;
        check("midrst_occ", 64'(occupancy), 64'd0);
        check("midrst_en", 64'(out_en), 64'd0);
        check("midrst_drained", 64'(drained), 64'd1);
        check("midrst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        sc_conflict = 1'b0;
        tick();
        check("post_rst_drained", 64'(drained), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
